// File: rtl/seg_scan_multi.sv
// Multiplexed seven-segment scanner with frame-synchronous display update,
// PWM dimming, leading-zero blanking and per-digit blink.
module seg_scan_multi #(
  parameter int unsigned DIGITS       = 6,
  parameter int unsigned SLOT_CYCLES  = 1000,
  parameter int unsigned DUTY_W       = 4,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blink_en,
  input  logic                  lz_blank,
  input  logic [DUTY_W-1:0]     bright,
  input  logic                  load,
  output logic                  pending,
  output logic                  frame_done,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            dig
);

  localparam int unsigned SW   = $clog2(SLOT_CYCLES);
  localparam int unsigned IW   = $clog2(DIGITS);
  localparam int unsigned FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned UNIT = SLOT_CYCLES >> DUTY_W;

  logic [SW-1:0]         slot_cnt_q, slot_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [4*DIGITS-1:0]   stg_din_q, stg_din_d, disp_din_q, disp_din_d;
  logic [DIGITS-1:0]     stg_dp_q, stg_dp_d, disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]     stg_blk_q, stg_blk_d, disp_blk_q, disp_blk_d;
  logic                  pending_q, pending_d;
  logic                  frame_done_q, frame_done_d;
  logic [DIGITS-1:0]     sel_q, sel_d;
  logic [7:0]            dig_q, dig_d;

  logic slot_last, eof;

  function automatic logic [6:0] seg_lut(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan counters, blink timebase and load/transfer bookkeeping
  always_comb begin
    slot_last     = (slot_cnt_q == SW'(SLOT_CYCLES - 1));
    eof           = slot_last && (idx_q == IW'(DIGITS - 1));
    slot_cnt_d    = slot_last ? '0 : slot_cnt_q + 1'b1;
    idx_d         = idx_q;
    if (slot_last) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (eof) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
    frame_done_d = eof;

    stg_din_d  = stg_din_q;
    stg_dp_d   = stg_dp_q;
    stg_blk_d  = stg_blk_q;
    disp_din_d = disp_din_q;
    disp_dp_d  = disp_dp_q;
    disp_blk_d = disp_blk_q;
    pending_d  = pending_q;
    if (load) begin
      stg_din_d = din;
      stg_dp_d  = dp;
      stg_blk_d = blink_en;
      pending_d = 1'b1;
    end
    if (eof) begin
      // A load landing on EOF bypasses staging so it is never left pending
      if (load) begin
        disp_din_d = din;
        disp_dp_d  = dp;
        disp_blk_d = blink_en;
      end else if (pending_q) begin
        disp_din_d = stg_din_q;
        disp_dp_d  = stg_dp_q;
        disp_blk_d = stg_blk_q;
      end
      pending_d = 1'b0;
    end
  end

  // Segment/select generation for the digit currently addressed by idx
  always_comb begin
    logic       all_zero;
    logic       blank;
    logic [3:0] nib;
    logic       dp_bit;
    logic       blk_bit;
    logic       on;
    logic [6:0] seg;
    all_zero = 1'b1;
    blank    = 1'b0;
    nib      = 4'h0;
    dp_bit   = 1'b0;
    blk_bit  = 1'b0;
    // Walk from the leftmost digit so all_zero covers nibbles i..DIGITS-1
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (disp_din_q[4*i +: 4] == 4'h0);
      if (IW'(i) == idx_q) begin
        nib     = disp_din_q[4*i +: 4];
        dp_bit  = disp_dp_q[i];
        blk_bit = disp_blk_q[i];
        blank   = all_zero && (i != 0);
      end
    end
    on  = (32'(slot_cnt_q) < (32'(bright) + 32'd1) * UNIT);
    seg = (lz_blank && blank) ? 7'h7F : seg_lut(nib);
    if (on) begin
      sel_d = ~(DIGITS'(1) << idx_q);
      dig_d = (blk_bit && blink_phase_q) ? 8'hFF : {~dp_bit, seg};
    end else begin
      sel_d = '1;
      dig_d = 8'hFF;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q    <= '0;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      stg_din_q     <= '0;
      stg_dp_q      <= '0;
      stg_blk_q     <= '0;
      disp_din_q    <= '0;
      disp_dp_q     <= '0;
      disp_blk_q    <= '0;
      pending_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      sel_q         <= '1;
      dig_q         <= 8'hFF;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      stg_din_q     <= stg_din_d;
      stg_dp_q      <= stg_dp_d;
      stg_blk_q     <= stg_blk_d;
      disp_din_q    <= disp_din_d;
      disp_dp_q     <= disp_dp_d;
      disp_blk_q    <= disp_blk_d;
      pending_q     <= pending_d;
      frame_done_q  <= frame_done_d;
      sel_q         <= sel_d;
      dig_q         <= dig_d;
    end
  end

  assign pending    = pending_q;
  assign frame_done = frame_done_q;
  assign sel        = sel_q;
  assign dig        = dig_q;

endmodule

// File: tb/tb_seg_scan_multi.sv
// Directed bench for seg_scan_multi with DIGITS=4, SLOT_CYCLES=16, DUTY_W=2, BLINK_FRAMES=2.
module tb_seg_scan_multi;

  localparam int unsigned ND = 4;
  localparam int FRAME = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   din;
  logic [3:0]    dp;
  logic [3:0]    blink_en;
  logic          lz_blank;
  logic [1:0]    bright;
  logic          load;
  logic          pending;
  logic          frame_done;
  logic [3:0]    sel;
  logic [7:0]    dig;

  int total = 0;
  int bad   = 0;
  int k     = 0;  // posedges since reset release; outputs now reflect counter state k-1

  seg_scan_multi #(
    .DIGITS       (ND),
    .SLOT_CYCLES  (16),
    .DUTY_W       (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .dp         (dp),
    .blink_en   (blink_en),
    .lz_blank   (lz_blank),
    .bright     (bright),
    .load       (load),
    .pending    (pending),
    .frame_done (frame_done),
    .sel        (sel),
    .dig        (dig)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic [3:0]  dp;
    logic        lz;
    logic [1:0]  bright;
    int          pos;
    logic [3:0]  sel;
    logic [7:0]  dig;
  } vec_t;

  vec_t vecs [24];

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired at k=%0d", nm, k);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    load = 1'b0;
    k    = 0;
  endtask

  task automatic wait_eof();
    int n = 0;
    do begin
      step();
      n++;
    end while (frame_done !== 1'b1 && n < 300);
    check("frame_done_seen", frame_done, 1);
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    do begin
      step();
      n++;
    end while (((k - 1) % FRAME) != p && n < 200);
    if (((k - 1) % FRAME) != p) timeout("wait_pos");
  endtask

  task automatic wait_abs(input int t);
    int n = 0;
    while ((k - 1) < t && n < 1000) begin
      step();
      n++;
    end
    if ((k - 1) != t) timeout("wait_abs");
  endtask

  task automatic load_val(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    din      = d;
    dp       = p;
    blink_en = b;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{16'h1234, 4'h0, 1'b0, 2'd3, 0*16+5,  4'b1110, 8'h99};
    vecs[1]  = '{16'h1234, 4'h0, 1'b0, 2'd3, 1*16+15, 4'b1101, 8'hB0};
    vecs[2]  = '{16'h1234, 4'h0, 1'b0, 2'd3, 2*16+7,  4'b1011, 8'hA4};
    vecs[3]  = '{16'h1234, 4'h0, 1'b0, 2'd3, 3*16+0,  4'b0111, 8'hF9};
    vecs[4]  = '{16'h1234, 4'h0, 1'b0, 2'd0, 2*16+3,  4'b1011, 8'hA4};
    vecs[5]  = '{16'h1234, 4'h0, 1'b0, 2'd0, 2*16+4,  4'b1111, 8'hFF};
    vecs[6]  = '{16'h1234, 4'h0, 1'b0, 2'd1, 0*16+7,  4'b1110, 8'h99};
    vecs[7]  = '{16'h1234, 4'h0, 1'b0, 2'd1, 0*16+8,  4'b1111, 8'hFF};
    vecs[8]  = '{16'h1234, 4'h0, 1'b0, 2'd2, 1*16+11, 4'b1101, 8'hB0};
    vecs[9]  = '{16'h0070, 4'h0, 1'b1, 2'd3, 3*16+2,  4'b0111, 8'hFF};
    vecs[10] = '{16'h0070, 4'h0, 1'b1, 2'd3, 2*16+2,  4'b1011, 8'hFF};
    vecs[11] = '{16'h0070, 4'h0, 1'b1, 2'd3, 1*16+2,  4'b1101, 8'hF8};
    vecs[12] = '{16'h0070, 4'h0, 1'b1, 2'd3, 0*16+2,  4'b1110, 8'hC0};
    vecs[13] = '{16'h0070, 4'h0, 1'b0, 2'd3, 3*16+2,  4'b0111, 8'hC0};
    vecs[14] = '{16'hABCD, 4'h4, 1'b0, 2'd3, 2*16+2,  4'b1011, 8'h03};
    vecs[15] = '{16'h89C0, 4'h0, 1'b1, 2'd3, 1*16+2,  4'b1101, 8'hC6};
    vecs[16] = '{16'h89C0, 4'h0, 1'b1, 2'd3, 0*16+2,  4'b1110, 8'hC0};
    vecs[17] = '{16'hE5F6, 4'h0, 1'b0, 2'd3, 3*16+2,  4'b0111, 8'h86};
    vecs[18] = '{16'hE5F6, 4'h0, 1'b0, 2'd3, 2*16+2,  4'b1011, 8'h92};
    vecs[19] = '{16'h0000, 4'h9, 1'b1, 2'd3, 3*16+2,  4'b0111, 8'h7F};
    vecs[20] = '{16'h0000, 4'h9, 1'b1, 2'd3, 0*16+2,  4'b1110, 8'h40};
    vecs[21] = '{16'h0102, 4'h0, 1'b1, 2'd3, 1*16+2,  4'b1101, 8'hC0};
    vecs[22] = '{16'h0102, 4'h0, 1'b1, 2'd3, 2*16+2,  4'b1011, 8'hF9};
    vecs[23] = '{16'hABCD, 4'h0, 1'b0, 2'd3, 0*16+2,  4'b1110, 8'hA1};

    rst = 1'b1; din = '0; dp = '0; blink_en = '0; lz_blank = 1'b0; bright = 2'd3; load = 1'b0;

    // Reset state
    do_reset();
    check("rst_sel", sel, 4'hF);
    check("rst_dig", dig, 8'hFF);
    check("rst_pending", pending, 0);
    check("rst_frame_done", frame_done, 0);

    // Table-driven scan / dimming / blanking / decode vectors
    for (int i = 0; i < 24; i++) begin
      lz_blank = vecs[i].lz;
      bright   = vecs[i].bright;
      load_val(vecs[i].din, vecs[i].dp, 4'h0);
      wait_eof();
      wait_pos(vecs[i].pos);
      check($sformatf("vec%0d_sel", i), sel, vecs[i].sel);
      check($sformatf("vec%0d_dig", i), dig, vecs[i].dig);
    end

    // Mid-frame load held until EOF; later load overwrites staging
    lz_blank = 1'b0;
    bright   = 2'd3;
    load_val(16'h1234, 4'h0, 4'h0);
    wait_eof();
    wait_pos(10);
    load_val(16'hABCD, 4'h0, 4'h0);
    check("mid_pending_set", pending, 1);
    wait_pos(16+5);
    check("mid_old_display", dig, 8'hB0);
    load_val(16'h5678, 4'h0, 4'h0);
    check("mid_pending_still", pending, 1);
    wait_eof();
    check("mid_pending_clr", pending, 0);
    wait_pos(5);
    check("last_wins_d0", dig, 8'h80);
    wait_pos(16+5);
    check("last_wins_d1", dig, 8'hF8);

    // Load coinciding with EOF goes straight to display
    begin
      int n = 0;
      while ((k % FRAME) != FRAME - 1 && n < 200) begin
        step();
        n++;
      end
      if ((k % FRAME) != FRAME - 1) timeout("find_eof");
    end
    load_val(16'h0009, 4'h0, 4'h0);
    check("eofload_pending", pending, 0);
    check("eofload_frame_done", frame_done, 1);
    step();
    check("eofload_sel", sel, 4'b1110);
    check("eofload_dig", dig, 8'h90);
    check("eofload_pending2", pending, 0);

    // Blink: digit 0 dark in frames 2-3, lit in 1 and 4; digit 1 unaffected
    do_reset();
    load_val(16'h1234, 4'h0, 4'b0001);
    wait_abs(1*FRAME + 2);
    check("blink_f1_d0", dig, 8'h99);
    wait_abs(2*FRAME + 2);
    check("blink_f2_d0", dig, 8'hFF);
    check("blink_f2_sel", sel, 4'b1110);
    wait_abs(2*FRAME + 16 + 2);
    check("blink_f2_d1", dig, 8'hB0);
    wait_abs(3*FRAME + 2);
    check("blink_f3_d0", dig, 8'hFF);
    wait_abs(4*FRAME + 2);
    check("blink_f4_d0", dig, 8'h99);

    // Reset mid-frame with a pending load, and load asserted during reset
    load_val(16'h9999, 4'h0, 4'h0);
    check("prerst_pending", pending, 1);
    din  = 16'h1111;
    load = 1'b1;
    do_reset();
    check("mrst_sel", sel, 4'hF);
    check("mrst_dig", dig, 8'hFF);
    check("mrst_pending", pending, 0);
    wait_abs(0);
    check("mrst_first_sel", sel, 4'b1110);
    check("mrst_first_dig", dig, 8'hC0);
    wait_abs(3*16 + 2);
    check("mrst_d3_sel", sel, 4'b0111);
    check("mrst_d3_dig", dig, 8'hC0);
    wait_abs(FRAME - 2);
    check("fd_before", frame_done, 0);
    step();
    check("fd_pulse", frame_done, 1);
    step();
    check("fd_after", frame_done, 0);
    wait_abs(FRAME + 16 + 2);
    check("mrst_discard_dig", dig, 8'hC0);
    check("mrst_discard_pending", pending, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
